// File: rtl/axi4s_elastic_fifo.sv
// axi4s_elastic_fifo: AXI4-Stream elastic buffer built on a DEPTH-entry circular store.
// Full-rate push/pop, registered upstream ready, first-word fall-through on the
// downstream side, and an optional store-and-forward (packet) mode with a
// deadlock escape for packets larger than the buffer.
module axi4s_elastic_fifo #(
  parameter int AXI_WIDTH   = 64,
  parameter int USER_WIDTH  = 1,
  parameter int DEPTH       = 4,
  parameter int PACKET_MODE = 0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [AXI_WIDTH-1:0]         m_tdata_i,
  input  logic                         m_tvalid_i,
  output logic                         m_tready_o,
  input  logic                         m_tlast_i,
  input  logic [AXI_WIDTH/8-1:0]       m_tkeep_i,
  input  logic [USER_WIDTH-1:0]        m_tuser_i,
  output logic [AXI_WIDTH-1:0]         s_tdata_o,
  output logic                         s_tvalid_o,
  input  logic                         s_tready_i,
  output logic                         s_tlast_o,
  output logic [AXI_WIDTH/8-1:0]       s_tkeep_o,
  output logic [USER_WIDTH-1:0]        s_tuser_o,
  output logic [$clog2(DEPTH+1)-1:0]   fill_level_o
);

  localparam int KEEP_W = AXI_WIDTH / 8;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int ENT_W  = AXI_WIDTH + KEEP_W + 1 + USER_WIDTH;

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  // Storage is deliberately not reset; entries are only read once valid.
  logic [ENT_W-1:0] r_mem [DEPTH];

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_pkt_count;
  logic             r_full;
  logic             r_fwd;
  logic             r_alive;

  logic             w_ready;
  logic             w_valid;
  logic             w_push;
  logic             w_pop;
  logic             w_rd_last;
  logic [ENT_W-1:0] w_rd_entry;
  logic [CNT_W-1:0] w_count_nxt;
  logic [CNT_W-1:0] w_pkt_nxt;
  logic             w_fwd_set;
  logic             w_fwd_nxt;

  // Upstream ready depends only on registers, never on s_tready_i.
  assign w_ready    = r_alive && !r_full;
  assign w_push     = m_tvalid_i && w_ready;
  assign w_pop      = w_valid && s_tready_i;
  assign w_rd_entry = r_mem[r_rd_ptr];
  assign w_rd_last  = w_rd_entry[USER_WIDTH];

  assign m_tready_o   = w_ready;
  assign s_tvalid_o   = w_valid;
  assign fill_level_o = r_count;
  assign {s_tdata_o, s_tkeep_o, s_tlast_o, s_tuser_o} = w_rd_entry;

  // Downstream valid: any beat in cut-through, a complete packet (or escape) in packet mode.
  always_comb begin
    w_valid = 1'b0;
    if (r_count == CNT_ZERO) begin
      w_valid = 1'b0;
    end else if (PACKET_MODE == 0) begin
      w_valid = 1'b1;
    end else begin
      w_valid = (r_pkt_count != CNT_ZERO) || r_fwd;
    end
  end

  // Occupancy update: simultaneous push and pop leave the count unchanged.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_ONE;
      2'b01:   w_count_nxt = r_count - CNT_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  // Number of stored packet terminators (beats with tlast set).
  always_comb begin
    w_pkt_nxt = r_pkt_count;
    case ({w_push && m_tlast_i, w_pop && w_rd_last})
      2'b10:   w_pkt_nxt = r_pkt_count + CNT_ONE;
      2'b01:   w_pkt_nxt = r_pkt_count - CNT_ONE;
      default: w_pkt_nxt = r_pkt_count;
    endcase
  end

  // Forwarding escape: a full buffer holding no tlast would otherwise never drain.
  assign w_fwd_set = r_full && (r_pkt_count == CNT_ZERO);

  // Escape flag holds until the oversize packet's tlast leaves, unless re-armed that cycle.
  always_comb begin
    w_fwd_nxt = r_fwd;
    if (PACKET_MODE == 0) begin
      w_fwd_nxt = 1'b0;
    end else if (w_fwd_set) begin
      w_fwd_nxt = 1'b1;
    end else if (w_pop && w_rd_last) begin
      w_fwd_nxt = 1'b0;
    end else begin
      w_fwd_nxt = r_fwd;
    end
  end

  // Control state: pointers, counts, full flag, escape flag and post-reset ready enable.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_pkt_count <= '0;
      r_full      <= 1'b0;
      r_fwd       <= 1'b0;
      r_alive     <= 1'b0;
    end else begin
      r_alive     <= 1'b1;
      r_count     <= w_count_nxt;
      r_pkt_count <= w_pkt_nxt;
      r_full      <= (w_count_nxt == CNT_FULL);
      r_fwd       <= w_fwd_nxt;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
    end
  end

  // Beat storage write: {data, keep, last, user} at the write pointer.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {m_tdata_i, m_tkeep_i, m_tlast_i, m_tuser_i};
    end
  end

endmodule

// File: tb/tb_axi4s_elastic_fifo.sv
// tb_axi4s_elastic_fifo: several FIFO configurations driven side by side and
// compared every cycle against a queue-based behavioural model of the buffer.
module tb_axi4s_elastic_fifo;

  localparam int NI = 5;
  localparam int DEP [NI] = '{4, 8, 4, 2, 16};
  localparam int MOD [NI] = '{0, 1, 1, 0, 0};

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic [1:0]  user;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        m_vld  [NI];
  logic [63:0] m_data [NI];
  logic        m_last [NI];
  logic [7:0]  m_keep [NI];
  logic [1:0]  m_user [NI];
  logic        m_rdy  [NI];
  logic [63:0] s_data [NI];
  logic        s_vld  [NI];
  logic        s_rdy  [NI];
  logic        s_last [NI];
  logic [7:0]  s_keep [NI];
  logic [1:0]  s_user [NI];
  logic [4:0]  s_fill [NI];

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int FW = $clog2(DEP[gi] + 1);
    logic [FW-1:0] fill_w;
    axi4s_elastic_fifo #(
      .AXI_WIDTH(64), .USER_WIDTH(2), .DEPTH(DEP[gi]), .PACKET_MODE(MOD[gi])
    ) u_dut (
      .clk_i(clk), .rst_i(rst),
      .m_tdata_i(m_data[gi]), .m_tvalid_i(m_vld[gi]), .m_tready_o(m_rdy[gi]),
      .m_tlast_i(m_last[gi]), .m_tkeep_i(m_keep[gi]), .m_tuser_i(m_user[gi]),
      .s_tdata_o(s_data[gi]), .s_tvalid_o(s_vld[gi]), .s_tready_i(s_rdy[gi]),
      .s_tlast_o(s_last[gi]), .s_tkeep_o(s_keep[gi]), .s_tuser_o(s_user[gi]),
      .fill_level_o(fill_w)
    );
    assign s_fill[gi] = 5'(fill_w);
  end

  // Reference model state
  beat_t q [NI][$];
  logic  alive [NI];
  logic  fwd   [NI];

  // Stimulus knobs and bookkeeping
  int          budget [NI];
  int          pv     [NI];
  int          pr     [NI];
  int          pktlen [NI];
  int          idx    [NI];
  int unsigned seq    [NI];
  logic        hs     [NI];

  // Observed-behaviour statistics
  int   pops [NI], pushes [NI], vldcyc [NI], fvp [NI], fpop [NI], lpop [NI], maxfill [NI];
  logic sawfull [NI];
  int   cyc;

  int n_checks;
  int n_errors;

  task automatic check_eq(input string tag, input int i, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s inst%0d got=%0h exp=%0h t=%0t", tag, i, got, exp, $time);
    end
  endtask

  function automatic int nlast(input int i);
    int c = 0;
    for (int k = 0; k < q[i].size(); k++) if (q[i][k].last) c++;
    return c;
  endfunction

  function automatic logic exp_vld(input int i);
    return (q[i].size() != 0) && (MOD[i] == 0 || nlast(i) != 0 || fwd[i]);
  endfunction

  function automatic logic exp_rdy(input int i);
    return alive[i] && (q[i].size() != DEP[i]);
  endfunction

  function automatic logic busy();
    logic b = 1'b0;
    for (int i = 0; i < NI; i++) if (budget[i] > 0 || q[i].size() != 0 || m_vld[i]) b = 1'b1;
    return b;
  endfunction

  task automatic regen(input int i);
    m_data[i] = {32'($urandom), 32'(seq[i])};
    m_keep[i] = 8'($urandom);
    m_user[i] = 2'($urandom);
    if (pktlen[i] > 0) m_last[i] = (idx[i] == pktlen[i] - 1);
    else               m_last[i] = (budget[i] == 1) || ($urandom_range(3) == 0);
  endtask

  task automatic reset_stats(input int i);
    pops[i] = 0; pushes[i] = 0; vldcyc[i] = 0; fvp[i] = -1;
    fpop[i] = -1; lpop[i] = -1; maxfill[i] = 0; sawfull[i] = 1'b0;
  endtask

  task automatic setup(input int i, input int b, input int v, input int r, input int pl);
    budget[i] = b; pv[i] = v; pr[i] = r; pktlen[i] = pl;
    if (!m_vld[i]) regen(i);
    reset_stats(i);
  endtask

  // Compare DUT outputs against the model (called away from the clock edge)
  task automatic check_all();
    beat_t f;
    for (int i = 0; i < NI; i++) begin
      check_eq("m_tready", i, 64'(m_rdy[i]), 64'(exp_rdy(i)));
      check_eq("s_tvalid", i, 64'(s_vld[i]), 64'(exp_vld(i)));
      check_eq("fill", i, 64'(s_fill[i]), 64'(q[i].size()));
      if (exp_vld(i)) begin
        f = q[i][0];
        check_eq("s_tdata", i, s_data[i], f.data);
        check_eq("s_tkeep", i, 64'(s_keep[i]), 64'(f.keep));
        check_eq("s_tlast", i, 64'(s_last[i]), 64'(f.last));
        check_eq("s_tuser", i, 64'(s_user[i]), 64'(f.user));
      end
      if (s_vld[i]) begin
        vldcyc[i]++;
        if (fvp[i] < 0) fvp[i] = pushes[i];
      end
      if (int'(s_fill[i]) > maxfill[i]) maxfill[i] = int'(s_fill[i]);
      if (int'(s_fill[i]) == DEP[i] && !m_rdy[i]) sawfull[i] = 1'b1;
    end
  endtask

  // Model transition for the coming clock edge
  task automatic advance();
    int n, nl;
    logic push, pop;
    beat_t b;
    for (int i = 0; i < NI; i++) begin
      if (!alive[i]) begin
        alive[i] = 1'b1;
      end else begin
        n    = q[i].size();
        nl   = nlast(i);
        push = m_vld[i] && (n != DEP[i]);
        pop  = exp_vld(i) && s_rdy[i];
        if (MOD[i] != 0 && n == DEP[i] && nl == 0) fwd[i] = 1'b1;
        else if (pop && q[i][0].last)               fwd[i] = 1'b0;
        if (pop) void'(q[i].pop_front());
        if (push) begin
          b.data = m_data[i]; b.keep = m_keep[i]; b.last = m_last[i]; b.user = m_user[i];
          q[i].push_back(b);
        end
      end
    end
  endtask

  task automatic pre();
    check_all();
    for (int i = 0; i < NI; i++) begin
      hs[i] = m_vld[i] && m_rdy[i];
      if (hs[i]) pushes[i]++;
      if (s_vld[i] && s_rdy[i]) begin
        pops[i]++;
        if (fpop[i] < 0) fpop[i] = cyc;
        lpop[i] = cyc;
      end
    end
    advance();
    cyc++;
  endtask

  task automatic post();
    for (int i = 0; i < NI; i++) begin
      if (hs[i]) begin
        budget[i]--;
        idx[i] = m_last[i] ? 0 : idx[i] + 1;
        seq[i]++;
        regen(i);
      end
      if (!(m_vld[i] && !hs[i])) m_vld[i] = (budget[i] > 0) && ($urandom_range(99) < pv[i]);
      s_rdy[i] = ($urandom_range(99) < pr[i]);
    end
  endtask

  task automatic step();
    pre();
    @(posedge clk);
    #1;
    post();
    @(negedge clk);
  endtask

  task automatic run_idle(input int maxc);
    int c = 0;
    while (busy() && c < maxc) begin
      step();
      c++;
    end
    check_eq("idle_timeout", 0, 64'(busy()), 64'(0));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc = 0;
    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      m_vld[i] = 1'b0; s_rdy[i] = 1'b0; alive[i] = 1'b0; fwd[i] = 1'b0;
      seq[i] = 0; idx[i] = 0; budget[i] = 0; pv[i] = 0; pr[i] = 0; pktlen[i] = 0;
      regen(i);
      reset_stats(i);
    end
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check_eq("rst_tready", i, 64'(m_rdy[i]), 64'(0));
      check_eq("rst_tvalid", i, 64'(s_vld[i]), 64'(0));
      check_eq("rst_fill", i, 64'(s_fill[i]), 64'(0));
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    // Continuous streaming through a cut-through FIFO
    setup(0, 100, 100, 100, 0);
    run_idle(400);
    check_eq("A_pops", 0, 64'(pops[0]), 64'(100));
    check_eq("A_rate", 0, 64'(lpop[0] - fpop[0]), 64'(99));
    check_eq("A_maxfill_le1", 0, 64'(maxfill[0] <= 1), 64'(1));

    // Fill with downstream stalled, then drain
    setup(0, 4, 100, 0, 0);
    repeat (6) step();
    check_eq("B_fill4", 0, 64'(s_fill[0]), 64'(4));
    check_eq("B_full_rdy", 0, 64'(m_rdy[0]), 64'(0));
    pr[0] = 100;
    step();
    check_eq("B_rdy_before_pop", 0, 64'(m_rdy[0]), 64'(0));
    step();
    check_eq("B_rdy_after_pop", 0, 64'(m_rdy[0]), 64'(1));
    run_idle(100);
    check_eq("B_pops", 0, 64'(pops[0]), 64'(4));

    // Store-and-forward: 3-beat packet, DEPTH 8
    setup(1, 3, 100, 100, 3);
    run_idle(100);
    check_eq("C_first_vld_pushes", 1, 64'(fvp[1]), 64'(3));
    check_eq("C_vld_cycles", 1, 64'(vldcyc[1]), 64'(3));
    check_eq("C_b2b", 1, 64'(lpop[1] - fpop[1]), 64'(2));
    check_eq("C_pops", 1, 64'(pops[1]), 64'(3));

    // Oversize packet escape, then a normal packet held until its tlast
    setup(2, 6, 100, 100, 6);
    run_idle(200);
    check_eq("D_sawfull", 2, 64'(sawfull[2]), 64'(1));
    check_eq("D_pops6", 2, 64'(pops[2]), 64'(6));
    setup(2, 2, 100, 100, 2);
    run_idle(100);
    check_eq("D_held_pushes", 2, 64'(fvp[2]), 64'(2));
    check_eq("D_pops2", 2, 64'(pops[2]), 64'(2));

    // Random traffic on every configuration
    for (int i = 0; i < NI; i++) setup(i, (i >= 3) ? 10000 : 2000, 50, 50, 0);
    run_idle(60000);
    for (int i = 0; i < NI; i++) check_eq("E_pops", i, 64'(pops[i]), 64'((i >= 3) ? 10000 : 2000));

    // Reset in the middle of a burst with 3 beats stored
    setup(0, 3, 100, 0, 0);
    repeat (5) step();
    check_eq("F_fill3", 0, 64'(s_fill[0]), 64'(3));
    pre();
    @(posedge clk);
    #1;
    post();
    rst = 1'b1;
    #1;
    check_eq("F_rst_tvalid", 0, 64'(s_vld[0]), 64'(0));
    check_eq("F_rst_fill", 0, 64'(s_fill[0]), 64'(0));
    check_eq("F_rst_tready", 0, 64'(m_rdy[0]), 64'(0));
    for (int i = 0; i < NI; i++) begin
      q[i].delete();
      alive[i] = 1'b0;
      fwd[i] = 1'b0;
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    setup(0, 5, 100, 100, 0);
    run_idle(100);
    check_eq("F_new_pops", 0, 64'(pops[0]), 64'(5));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
